// File: rtl/msi_bus_arbiter.sv
// Shared snooping-bus arbiter for MSI cache controllers and one memory.
// Round-robin grant, snoop broadcast, optional M-state flush preemption, then the owner's memory access.
module msi_bus_arbiter #(
    parameter int unsigned NUM_CORES    = 2,
    parameter int unsigned SNOOP_CYCLES = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_CORES-1:0]    bus_request,
    input  logic [3*NUM_CORES-1:0]  bus_op_out,
    input  logic [5*NUM_CORES-1:0]  bus_addr_out,
    input  logic [16*NUM_CORES-1:0] bus_dout,
    input  logic [NUM_CORES-1:0]    bus_done_out,
    output logic [NUM_CORES-1:0]    bus_grant,
    output logic [3*NUM_CORES-1:0]  bus_op_in,
    output logic [4:0]              bus_addr_in,
    output logic [15:0]             bus_din,
    output logic [NUM_CORES-1:0]    bus_done_in,
    output logic [4:0]              mem_addr,
    output logic                    mem_rd,
    output logic                    mem_wr,
    output logic [15:0]             mem_wdata,
    input  logic [15:0]             mem_rdata,
    input  logic                    mem_done
);

    localparam int unsigned OP_W   = 3;
    localparam int unsigned ADDR_W = 5;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned IDX_W  = $clog2(NUM_CORES);
    localparam int unsigned CNT_W  = (SNOOP_CYCLES > 1) ? $clog2(SNOOP_CYCLES) : 1;

    localparam logic [OP_W-1:0] OP_NONE  = 3'b000;
    localparam logic [OP_W-1:0] OP_RD    = 3'b001;
    localparam logic [OP_W-1:0] OP_UPGR  = 3'b010;
    localparam logic [OP_W-1:0] OP_FLUSH = 3'b011;
    localparam logic [OP_W-1:0] OP_RDX   = 3'b100;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_GRANT   = 3'd1;
    localparam logic [2:0] S_SNOOP   = 3'd2;
    localparam logic [2:0] S_FLUSH   = 3'd3;
    localparam logic [2:0] S_MEM     = 3'd4;
    localparam logic [2:0] S_RELEASE = 3'd5;

    logic [2:0]             state_q,      state_d;
    logic [IDX_W-1:0]       rr_q,         rr_d;
    logic [IDX_W-1:0]       owner_q,      owner_d;
    logic [IDX_W-1:0]       flusher_q,    flusher_d;
    logic [OP_W-1:0]        op_q,         op_d;
    logic [ADDR_W-1:0]      addr_q,       addr_d;
    logic [CNT_W-1:0]       cnt_q,        cnt_d;
    logic [NUM_CORES-1:0]   grant_q,      grant_d;
    logic [3*NUM_CORES-1:0] snoop_op_q,   snoop_op_d;
    logic [ADDR_W-1:0]      snoop_addr_q, snoop_addr_d;
    logic [DATA_W-1:0]      bus_din_q,    bus_din_d;
    logic [NUM_CORES-1:0]   done_in_q,    done_in_d;
    logic [ADDR_W-1:0]      mem_addr_q,   mem_addr_d;
    logic                   mem_rd_q,     mem_rd_d;
    logic                   mem_wr_q,     mem_wr_d;
    logic [DATA_W-1:0]      mem_wdata_q,  mem_wdata_d;

    logic [OP_W-1:0]   core_op   [NUM_CORES];
    logic [ADDR_W-1:0] core_addr [NUM_CORES];
    logic [DATA_W-1:0] core_data [NUM_CORES];

    logic             arb_found;
    logic [IDX_W-1:0] arb_idx;
    int               arb_cand;
    logic             fl_found;
    logic [IDX_W-1:0] fl_idx;
    logic             enter_mem;

    // Per-core views of the packed request buses.
    for (genvar k = 0; k < NUM_CORES; k++) begin : g_unpack
        assign core_op[k]   = bus_op_out[OP_W*k +: OP_W];
        assign core_addr[k] = bus_addr_out[ADDR_W*k +: ADDR_W];
        assign core_data[k] = bus_dout[DATA_W*k +: DATA_W];
    end

    always_comb begin
        state_d      = state_q;
        rr_d         = rr_q;
        owner_d      = owner_q;
        flusher_d    = flusher_q;
        op_d         = op_q;
        addr_d       = addr_q;
        cnt_d        = cnt_q;
        grant_d      = grant_q;
        snoop_op_d   = snoop_op_q;
        snoop_addr_d = snoop_addr_q;
        bus_din_d    = bus_din_q;
        done_in_d    = '0;
        mem_addr_d   = mem_addr_q;
        mem_rd_d     = mem_rd_q;
        mem_wr_d     = mem_wr_q;
        mem_wdata_d  = mem_wdata_q;
        enter_mem    = 1'b0;

        // Round-robin: first requester strictly after the last winner.
        arb_found = 1'b0;
        arb_idx   = '0;
        arb_cand  = 0;
        for (int i = 1; i <= int'(NUM_CORES); i++) begin
            arb_cand = (int'(rr_q) + i) % int'(NUM_CORES);
            if (!arb_found && bus_request[IDX_W'(arb_cand)]) begin
                arb_found = 1'b1;
                arb_idx   = IDX_W'(arb_cand);
            end
        end

        // Lowest-index snooper holding the block in M wants to flush it.
        fl_found = 1'b0;
        fl_idx   = '0;
        for (int k = 0; k < int'(NUM_CORES); k++) begin
            if (!fl_found && IDX_W'(k) != owner_q && bus_request[k]
                && core_op[k] == OP_FLUSH && core_addr[k] == addr_q) begin
                fl_found = 1'b1;
                fl_idx   = IDX_W'(k);
            end
        end

        case (state_q)
            S_IDLE: begin
                if (arb_found) begin
                    grant_d          = '0;
                    grant_d[arb_idx] = 1'b1;
                    owner_d          = arb_idx;
                    rr_d             = arb_idx;
                    state_d          = S_GRANT;
                end
            end
            S_GRANT: begin
                if (core_op[owner_q] == OP_RD || core_op[owner_q] == OP_RDX
                    || core_op[owner_q] == OP_UPGR) begin
                    op_d         = core_op[owner_q];
                    addr_d       = core_addr[owner_q];
                    snoop_addr_d = core_addr[owner_q];
                    cnt_d        = '0;
                    for (int k = 0; k < int'(NUM_CORES); k++) begin
                        snoop_op_d[OP_W*k +: OP_W] =
                            (IDX_W'(k) == owner_q) ? OP_NONE : core_op[owner_q];
                    end
                    state_d = S_SNOOP;
                end else if (core_op[owner_q] == OP_FLUSH) begin
                    op_d      = OP_FLUSH;
                    addr_d    = core_addr[owner_q];
                    enter_mem = 1'b1;
                end
            end
            S_SNOOP: begin
                if (fl_found) begin
                    grant_d[fl_idx] = 1'b1;
                    flusher_d       = fl_idx;
                    mem_wr_d        = 1'b1;
                    mem_addr_d      = addr_q;
                    mem_wdata_d     = core_data[fl_idx];
                    state_d         = S_FLUSH;
                end else if (cnt_q == CNT_W'(SNOOP_CYCLES - 1)) begin
                    enter_mem = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_FLUSH: begin
                // mem_wr low means the write finished and we await the flusher's ack.
                if (mem_wr_q) begin
                    mem_wdata_d = core_data[flusher_q];
                    if (mem_done) begin
                        mem_wr_d             = 1'b0;
                        done_in_d[flusher_q] = 1'b1;
                    end
                end else if (bus_done_out[flusher_q]) begin
                    grant_d[flusher_q] = 1'b0;
                    enter_mem          = 1'b1;
                end
            end
            S_MEM: begin
                if (op_q == OP_UPGR) begin
                    done_in_d[owner_q] = 1'b1;
                    state_d            = S_RELEASE;
                end else begin
                    if (mem_wr_q) begin
                        mem_wdata_d = core_data[owner_q];
                    end
                    if (mem_done) begin
                        mem_rd_d = 1'b0;
                        mem_wr_d = 1'b0;
                        if (mem_rd_q) begin
                            bus_din_d = mem_rdata;
                        end
                        done_in_d[owner_q] = 1'b1;
                        state_d            = S_RELEASE;
                    end
                end
            end
            S_RELEASE: begin
                if (bus_done_out[owner_q]) begin
                    grant_d = '0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                grant_d  = '0;
                mem_rd_d = 1'b0;
                mem_wr_d = 1'b0;
                state_d  = S_IDLE;
            end
        endcase

        // Common entry into the owner's memory phase; snoop broadcast ends here.
        if (enter_mem) begin
            state_d      = S_MEM;
            snoop_op_d   = '0;
            snoop_addr_d = '0;
            mem_addr_d   = addr_d;
            if (op_d == OP_RD || op_d == OP_RDX) begin
                mem_rd_d = 1'b1;
            end else if (op_d == OP_FLUSH) begin
                mem_wr_d    = 1'b1;
                mem_wdata_d = core_data[owner_q];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            rr_q         <= IDX_W'(NUM_CORES - 1);
            owner_q      <= '0;
            flusher_q    <= '0;
            op_q         <= OP_NONE;
            addr_q       <= '0;
            cnt_q        <= '0;
            grant_q      <= '0;
            snoop_op_q   <= '0;
            snoop_addr_q <= '0;
            bus_din_q    <= '0;
            done_in_q    <= '0;
            mem_addr_q   <= '0;
            mem_rd_q     <= 1'b0;
            mem_wr_q     <= 1'b0;
            mem_wdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            rr_q         <= rr_d;
            owner_q      <= owner_d;
            flusher_q    <= flusher_d;
            op_q         <= op_d;
            addr_q       <= addr_d;
            cnt_q        <= cnt_d;
            grant_q      <= grant_d;
            snoop_op_q   <= snoop_op_d;
            snoop_addr_q <= snoop_addr_d;
            bus_din_q    <= bus_din_d;
            done_in_q    <= done_in_d;
            mem_addr_q   <= mem_addr_d;
            mem_rd_q     <= mem_rd_d;
            mem_wr_q     <= mem_wr_d;
            mem_wdata_q  <= mem_wdata_d;
        end
    end

    assign bus_grant   = grant_q;
    assign bus_op_in   = snoop_op_q;
    assign bus_addr_in = snoop_addr_q;
    assign bus_din     = bus_din_q;
    assign bus_done_in = done_in_q;
    assign mem_addr    = mem_addr_q;
    assign mem_rd      = mem_rd_q;
    assign mem_wr      = mem_wr_q;
    assign mem_wdata   = mem_wdata_q;

endmodule

// File: tb/tb_msi_bus_arbiter.sv
// Scoreboard bench for msi_bus_arbiter: a latency memory model plus directed cache-side sequences.
module tb_msi_bus_arbiter;

    localparam int unsigned NC      = 2;
    localparam int unsigned SC      = 2;
    localparam int          MEM_LAT = 3;

    localparam logic [2:0] OP_NONE  = 3'b000;
    localparam logic [2:0] OP_RD    = 3'b001;
    localparam logic [2:0] OP_UPGR  = 3'b010;
    localparam logic [2:0] OP_FLUSH = 3'b011;
    localparam logic [2:0] OP_RDX   = 3'b100;

    typedef struct { bit wr; logic [4:0] addr; logic [15:0] data; } mem_exp_t;
    typedef struct { int core; bit chk_din; logic [15:0] din; } done_exp_t;

    logic              clk;
    logic              reset;
    logic [NC-1:0]     bus_request;
    logic [3*NC-1:0]   bus_op_out;
    logic [5*NC-1:0]   bus_addr_out;
    logic [16*NC-1:0]  bus_dout;
    logic [NC-1:0]     bus_done_out;
    logic [NC-1:0]     bus_grant;
    logic [3*NC-1:0]   bus_op_in;
    logic [4:0]        bus_addr_in;
    logic [15:0]       bus_din;
    logic [NC-1:0]     bus_done_in;
    logic [4:0]        mem_addr;
    logic              mem_rd;
    logic              mem_wr;
    logic [15:0]       mem_wdata;
    logic [15:0]       mem_rdata;
    logic              mem_done;

    int n_checks = 0;
    int n_fail   = 0;
    mem_exp_t  mem_q[$];
    done_exp_t done_q[$];
    mem_exp_t  me;
    done_exp_t de;
    logic [15:0] ref_mem [32];
    logic [15:0] mem_arr [32];
    int mem_cnt = 0;

    msi_bus_arbiter #(.NUM_CORES(NC), .SNOOP_CYCLES(SC)) dut (
        .clk          (clk),
        .reset        (reset),
        .bus_request  (bus_request),
        .bus_op_out   (bus_op_out),
        .bus_addr_out (bus_addr_out),
        .bus_dout     (bus_dout),
        .bus_done_out (bus_done_out),
        .bus_grant    (bus_grant),
        .bus_op_in    (bus_op_in),
        .bus_addr_in  (bus_addr_in),
        .bus_din      (bus_din),
        .bus_done_in  (bus_done_in),
        .mem_addr     (mem_addr),
        .mem_rd       (mem_rd),
        .mem_wr       (mem_wr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .mem_done     (mem_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Memory with fixed latency; checks each access against the expected queue when it starts.
    always @(posedge clk) begin
        #1;
        mem_done  = 1'b0;
        mem_rdata = 16'($urandom);
        if (!(mem_rd || mem_wr)) begin
            mem_cnt = 0;
        end else begin
            if (mem_cnt == 0) begin
                if (mem_q.size() == 0) begin
                    chk("mem_unexpected", 32'(mem_addr), 32'hFFFF_FFFF);
                end else begin
                    me = mem_q.pop_front();
                    chk("mem_is_wr", 32'(mem_wr), 32'(me.wr));
                    chk("mem_addr", 32'(mem_addr), 32'(me.addr));
                    if (me.wr) chk("mem_wdata", 32'(mem_wdata), 32'(me.data));
                end
            end
            mem_cnt++;
            if (mem_cnt == MEM_LAT) begin
                mem_done = 1'b1;
                if (mem_wr) mem_arr[mem_addr] = mem_wdata;
                else        mem_rdata = mem_arr[mem_addr];
            end
        end
    end

    // Done-pulse scoreboard and bus invariants.
    always @(posedge clk) begin
        #1;
        if (!reset) begin
            chk("inv_gnt_le2", 32'($countones(bus_grant) <= 2), 32'd1);
            chk("inv_rd_wr", 32'(mem_rd & mem_wr), 32'd0);
            for (int k = 0; k < int'(NC); k++) begin
                if (bus_done_in[k]) begin
                    if (done_q.size() == 0) begin
                        chk("done_unexpected", 32'(k), 32'hFFFF_FFFF);
                    end else begin
                        de = done_q.pop_front();
                        chk("done_core", 32'(k), 32'(de.core));
                        if (de.chk_din) chk("bus_din", 32'(bus_din), 32'(de.din));
                    end
                end
            end
        end
    end

    task automatic do_reset();
        reset        = 1'b1;
        bus_request  = '0;
        bus_op_out   = '0;
        bus_done_out = '0;
        repeat (2) begin @(posedge clk); #1; end
        chk("rst_grant", 32'(bus_grant), 32'd0);
        chk("rst_op_in", 32'(bus_op_in), 32'd0);
        chk("rst_addr_in", 32'(bus_addr_in), 32'd0);
        chk("rst_din", 32'(bus_din), 32'd0);
        chk("rst_done_in", 32'(bus_done_in), 32'd0);
        chk("rst_mem_rw", 32'({mem_rd, mem_wr}), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        reset = 1'b0;
        done_q.delete();
    endtask

    // One full transaction by core own; fl >= 0 makes that core flush during snoop.
    task automatic run_txn(input int own, input logic [2:0] op, input logic [4:0] addr,
                           input logic [15:0] data, input int fl, input logic [15:0] fdata);
        int cyc;
        int snoop_cyc;
        bit fl_started;
        bit fl_done;
        bit own_done;
        logic [3*NC-1:0] exp_snoop;
        exp_snoop = '0;
        for (int k = 0; k < int'(NC); k++) if (k != own) exp_snoop[3*k +: 3] = op;
        if (fl >= 0) begin
            mem_q.push_back('{1'b1, addr, fdata});
            ref_mem[addr] = fdata;
            done_q.push_back('{fl, 1'b0, 16'h0});
        end
        if (op == OP_RD || op == OP_RDX) begin
            mem_q.push_back('{1'b0, addr, 16'h0});
            done_q.push_back('{own, 1'b1, ref_mem[addr]});
        end else if (op == OP_FLUSH) begin
            mem_q.push_back('{1'b1, addr, data});
            ref_mem[addr] = data;
            done_q.push_back('{own, 1'b0, 16'h0});
        end else begin
            done_q.push_back('{own, 1'b0, 16'h0});
        end

        bus_request[own] = 1'b1;
        cyc = 0;
        do begin @(posedge clk); #1; cyc++; end while (bus_grant == '0 && cyc < 20);
        chk("gnt_vec", 32'(bus_grant), 32'(1 << own));
        chk("gnt_lat", 32'(cyc), 32'd1);
        bus_request[own]           = 1'b0;
        bus_op_out[3*own +: 3]     = op;
        bus_addr_out[5*own +: 5]   = addr;
        bus_dout[16*own +: 16]     = data;

        snoop_cyc  = 0;
        fl_started = 1'b0;
        fl_done    = 1'b0;
        own_done   = 1'b0;
        cyc        = 0;
        while (!own_done && cyc < 200) begin
            @(posedge clk); #1; cyc++;
            bus_done_out = '0;
            if (bus_op_in != '0) begin
                snoop_cyc++;
                chk("snoop_op", 32'(bus_op_in), 32'(exp_snoop));
                chk("snoop_addr", 32'(bus_addr_in), 32'(addr));
                if (fl >= 0 && !fl_started) begin
                    bus_request[fl]         = 1'b1;
                    bus_op_out[3*fl +: 3]   = OP_FLUSH;
                    bus_addr_out[5*fl +: 5] = addr;
                    bus_dout[16*fl +: 16]   = fdata;
                    fl_started              = 1'b1;
                end
            end
            if (fl >= 0 && fl_started && !fl_done && bus_done_in[fl]) begin
                chk("fl_gnt", 32'(bus_grant), 32'((1 << own) | (1 << fl)));
                bus_done_out[fl]      = 1'b1;
                bus_request[fl]       = 1'b0;
                bus_op_out[3*fl +: 3] = OP_NONE;
                fl_done               = 1'b1;
            end
            if (bus_done_in[own]) begin
                chk("own_gnt", 32'(bus_grant), 32'(1 << own));
                bus_done_out[own]      = 1'b1;
                bus_op_out[3*own +: 3] = OP_NONE;
                own_done               = 1'b1;
            end
        end
        chk("own_done_seen", 32'(own_done), 32'd1);
        if (fl >= 0) chk("fl_done_seen", 32'(fl_done), 32'd1);
        else         chk("snoop_cycles", 32'(snoop_cyc), (op == OP_FLUSH) ? 32'd0 : 32'(SC));
        @(posedge clk); #1;
        bus_done_out = '0;
        chk("released", 32'(bus_grant), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cyc;
        reset        = 1'b1;
        bus_request  = '0;
        bus_op_out   = '0;
        bus_addr_out = '0;
        bus_dout     = '0;
        bus_done_out = '0;
        mem_rdata    = '0;
        mem_done     = 1'b0;
        for (int a = 0; a < 32; a++) begin
            ref_mem[a] = 16'hA000 + 16'(a);
            mem_arr[a] = 16'hA000 + 16'(a);
        end
        do_reset();

        run_txn(0, OP_RD, 5'd4, 16'h0, -1, 16'h0);
        run_txn(0, OP_RDX, 5'd8, 16'h0, 1, 16'h0D0C);
        run_txn(1, OP_UPGR, 5'd1, 16'h0, -1, 16'h0);
        run_txn(0, OP_FLUSH, 5'd0, 16'hBEEF, -1, 16'h0);

        // Contending requesters must alternate starting from core 0.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            bus_request = '1;
            run_txn(i % 2, OP_RD, 5'(2 + i), 16'h0, -1, 16'h0);
        end
        bus_request = '0;

        // Reset in the middle of a memory read aborts the transaction.
        mem_q.push_back('{1'b0, 5'd5, 16'h0});
        bus_request[0] = 1'b1;
        cyc = 0;
        do begin @(posedge clk); #1; cyc++; end while (bus_grant == '0 && cyc < 20);
        chk("t6_gnt", 32'(bus_grant), 32'd1);
        bus_request[0]    = 1'b0;
        bus_op_out[2:0]   = OP_RD;
        bus_addr_out[4:0] = 5'd5;
        cyc = 0;
        do begin @(posedge clk); #1; cyc++; end while (!mem_rd && cyc < 20);
        chk("t6_mem_rd_seen", 32'(mem_rd), 32'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("t6_rst_grant", 32'(bus_grant), 32'd0);
        chk("t6_rst_mem_rd", 32'(mem_rd), 32'd0);
        chk("t6_rst_mem_wr", 32'(mem_wr), 32'd0);
        chk("t6_rst_op_in", 32'(bus_op_in), 32'd0);
        reset      = 1'b0;
        bus_op_out = '0;
        done_q.delete();
        run_txn(1, OP_RD, 5'd9, 16'h0, -1, 16'h0);

        repeat (3) @(posedge clk);
        #1;
        chk("mem_q_empty", 32'(mem_q.size()), 32'd0);
        chk("done_q_empty", 32'(done_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/msi_bus_arbiter.md
Name: msi_bus_arbiter

Overview:
- Shared-bus arbiter and sequencer for NUM_CORES CacheMSI-style snooping cache controllers and one Memory instance.
- Grants the bus round-robin to one owner and broadcasts the owner's op/address to the other caches as snoop input.
- Lets a snooping cache with the block in M preempt the transaction to flush, then performs the owner's memory access and releases the bus.

Parameters:
NUM_CORES, 2, number of cache controllers (2..4)
SNOOP_CYCLES, 2, cycles the snoop op is broadcast before the owner's memory access starts (>=1)

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
bus_request  in  NUM_CORES  per-core bus request
bus_op_out  in  3*NUM_CORES  per-core op: None=000, Rd=001, Upgr=010, Flush=011, RdX=100; core k at [3k+2:3k]
bus_addr_out  in  5*NUM_CORES  per-core block address
bus_dout  in  16*NUM_CORES  per-core flush data
bus_done_out  in  NUM_CORES  per-core end-of-transaction pulse
bus_grant  out  NUM_CORES  per-core grant
bus_op_in  out  3*NUM_CORES  per-core snoop op
bus_addr_in  out  5  shared snoop address (owner's)
bus_din  out  16  shared data to caches (= mem_rdata)
bus_done_in  out  NUM_CORES  per-core data/ack pulse
mem_addr  out  5  memory block address
mem_rd  out  1  memory read level
mem_wr  out  1  memory write level
mem_wdata  out  16  memory write data
mem_rdata  in  16  memory read data
mem_done  in  1  memory completion pulse

Behaviour:
- Reset: state IDLE; all outputs 0 (op 000 = None); rr pointer = NUM_CORES-1, so core 0 wins first. Reset mid-transaction aborts immediately: grants, mem_rd and mem_wr drop on the next edge.
- Arbitration (IDLE): pick the first requester after the rr pointer (wrapping) and register bus_grant[w]=1 one cycle after the request is seen; rr pointer = w; go GRANT.
- GRANT: owner grant is held. Wait for owner bus_op_out != None, then latch op and addr.
  - Rd, RdX or Upgr: go SNOOP.
  - Flush: go MEM directly.
- SNOOP: bus_op_in[k] = latched op for every k != owner; bus_op_in[owner] = None; bus_addr_in = latched addr. A counter runs SNOOP_CYCLES cycles. In any SNOOP cycle, if a non-owner has bus_request=1, op=Flush and addr equal to the latched addr, the lowest such index f wins: assert bus_grant[f] (owner grant stays high) and go FLUSH. When the counter expires with no flush, go MEM.
- FLUSH: mem_wr=1, mem_addr=latched addr, mem_wdata=bus_dout[f], held until mem_done. On mem_done: drop mem_wr and pulse bus_done_in[f] for one cycle. Wait for bus_done_out[f], then drop bus_grant[f] and go MEM. At most one flush per transaction. Snoop broadcast is held through FLUSH.
- MEM: snoop broadcast goes back to None.
  - Rd/RdX: mem_rd=1 until mem_done; bus_din = mem_rdata; bus_done_in[owner] pulses the cycle after mem_done.
  - Flush: mem_wr=1 with owner's bus_dout until mem_done; bus_done_in[owner] pulses the cycle after mem_done.
  - Upgr: no memory access; bus_done_in[owner] pulses the cycle after MEM is entered.
  - Then go RELEASE.
- RELEASE: wait for bus_done_out[owner], then drop bus_grant and go IDLE. A new grant comes no earlier than the next cycle.
- Invariants:
  - At most 2 grants high (owner plus flusher); mem_rd and mem_wr never both high.
  - Requests from the current owner are ignored until IDLE.
  - A request dropped before grant is simply not served.
  - Owner request dropping after grant does not release the bus; only bus_done_out does.

Test Plan:
- Core0 request, BusRd addr 4, no snooper flush -> grant0 next cycle; bus_op_in[core1] = Rd for 2 cycles; mem_rd addr 4; bus_done_in[0] pulse; release on bus_done_out[0].
- Cores 0 and 1 request together repeatedly -> grants alternate 0,1,0,1; never overlap.
- Core0 BusRdX addr 8 while core1 raises Flush addr 8 in SNOOP with data 0x0D0C -> mem write 0x0D0C at addr 8; bus_done_in[1]; then mem_rd addr 8; bus_done_in[0].
- Core1 BusUpgr addr 1 -> no mem_rd/mem_wr; bus_op_in[core0] = Upgr; bus_done_in[1] pulse; release.
- Core0 BusFlush addr 0 -> no snoop broadcast; mem_wr with owner data; done pulse.
- Reset asserted during MEM read -> next edge: all grants 0, mem_rd 0, IDLE; a subsequent core1 request is served.
